uop_sequencer: RTL
==================

# uop_sequencer

Sits between `decode_unit` and the execute stage. Accepts decoded micro-op bundles (1–3 uops of 20 bits each) over the decoder's `feed_req`/`feed_ack` handshake and buffers them in a small FIFO of bundles. It then issues the uops to execute one per cycle, in the required order, under a valid/ready handshake. A flush from branch or PC redirect discards all buffered and partially issued work.

## Interface
Parameters:
- `UOP_W`, default 20: micro-op width.
- `DEPTH`, default 2: bundle FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`, in, 1: clock.
- `a_rst`, in, 1: reset; asynchronous, active-low.
- `flush`, in, 1: discard all buffered bundles and the in-progress bundle.
- `feed_req`, out, 1: a free bundle slot exists; drives the decoder's `feed_req`.
- `feed_ack`, in, 1: the decoder delivers a bundle this cycle.
- `uop_0`, `uop_1`, `uop_2`, in, UOP_W each: bundle contents.
- `uop_count`, in, 2: number of uops in the bundle minus one.
- `uop_out`, out, UOP_W: micro-op presented to execute.
- `uop_valid`, out, 1: `uop_out` is valid.
- `uop_ready`, in, 1: execute accepts `uop_out` this cycle.
- `uop_last`, out, 1: `uop_out` is the final uop of its bundle.
- `busy`, out, 1: FIFO non-empty or an issue is in progress.

## Operation
- **Capture:** a bundle is written at the posedge when `feed_ack & feed_req`.
  - Stored fields: all three uops plus the clamped count.
  - `uop_count` = 3 is treated as 2.
  - `feed_ack` while `feed_req` = 0 is ignored and nothing is written; the bench flags it as an error.
- **`feed_req`:** equals `occupancy < DEPTH`, computed from registered occupancy. There is no same-cycle slot reuse.
- **Issue order per bundle:**
  - count 0: `uop_0`.
  - count 1: `uop_1`, then `uop_0`.
  - count 2: `uop_2`, then `uop_1`, then `uop_0`.
- **Head state machine:**
  - EMPTY → ISSUE when occupancy becomes non-zero. `step` loads the head's count.
  - In ISSUE:
    - `uop_out = head.uop[step]`.
    - On `uop_valid & uop_ready`: if `step` = 0, pop the head and go to ISSUE with the next head's count, or to EMPTY if none remain. Otherwise decrement `step`.
- **`uop_last`:** equals `uop_valid & (step == 0)`.
- **Stall:** while `uop_ready` = 0, `uop_out`, `uop_valid` and `step` hold stable. A valid uop must not be withdrawn except by flush or reset.
- **Flush:** at the posedge with `flush` = 1:
  - occupancy, pointers and `step` clear; state goes to EMPTY.
  - A same-cycle `feed_ack` bundle is discarded; flush wins.
  - A same-cycle `uop_valid & uop_ready` transfer counts as completed.
- **Simultaneous push and pop:** occupancy stays unchanged. Pointers wrap modulo DEPTH.
- **Reset mid-bundle:** all state clears asynchronously and the remaining uops are lost.

## Timing
- **Reset values:** `uop_valid` 0, `uop_last` 0, `uop_out` 0, `busy` 0, `feed_req` 1, occupancy 0, state EMPTY.
- **Latency:** the first uop is valid on the cycle after capture (1 cycle).
- **Throughput:** with `uop_ready` held at 1, a bundle of N uops issues in N consecutive cycles. Back-to-back bundles issue with no bubble.
- **Output paths:** `uop_out`, `uop_valid` and `uop_last` are driven from registered state only. There is no combinational path from the decoder inputs.
- **After flush:** `uop_valid` is 0 in the cycle after flush and `feed_req` is 1.

## Configuration
`UOP_SEQ_BYPASS_EN`:
- **Defined:** when occupancy is 0 and `flush` = 0, a `feed_ack` bundle with `uop_count` = 0 drives `uop_out = uop_0`, `uop_valid` = 1 and `uop_last` = 1 combinationally in the same cycle.
  - If `uop_ready` = 1, the bundle is not written.
  - Otherwise it is written normally and reissued next cycle.
  - This creates a combinational path from the decoder inputs to `uop_out`.
- **Undefined:** no bypass. Fixed 1-cycle latency and registered-only outputs.

## Test plan
- **Single-uop bundle:** reset, then push a bundle with count 0, `uop_0` = 0x12345, `uop_ready` = 1 → next cycle `uop_out` = 0x12345, `uop_valid` = 1, `uop_last` = 1; `busy` is 0 the cycle after.
- **Three-uop order and back-to-back:** push count 2 with `uop_2`/`uop_1`/`uop_0` = 0xAAAAA/0xBBBBB/0xCCCCC, then immediately a count-1 bundle 0x11111/0x22222 → consecutive outputs AAAAA, BBBBB, CCCCC(last), 11111, 22222(last), with no gaps.
- **Stall and full:** hold `uop_ready` = 0 and push DEPTH bundles → `feed_req` = 0, `uop_out` stable at the first bundle's first uop. A third `feed_ack` is ignored.
- **Flush mid-bundle:** assert `flush` during the 2nd uop of a count-2 bundle, with a same-cycle `feed_ack` → next cycle `uop_valid` = 0, `busy` = 0, `feed_req` = 1, and the acked bundle never issues.
- **Count 3 clamp:** `uop_count` = 3 issues exactly `uop_2`, `uop_1`, `uop_0`.
- **Bypass:** with `UOP_SEQ_BYPASS_EN` defined, empty FIFO, a count-0 push with `uop_ready` = 1 → `uop_valid` is 1 in the same cycle and occupancy stays 0. Without the macro, `uop_valid` rises one cycle later.

Source files
------------

// File: rtl/uop_sequencer_if.sv
// Decoder-feed and execute-issue signals of the uop sequencer.
// master is the sequencer's view; slave is the surrounding pipeline's view.
interface uop_sequencer_if #(
  parameter int UOP_W = 20
);
  logic             flush;
  logic             feed_req;
  logic             feed_ack;
  logic [UOP_W-1:0] uop_0;
  logic [UOP_W-1:0] uop_1;
  logic [UOP_W-1:0] uop_2;
  logic [1:0]       uop_count;
  logic [UOP_W-1:0] uop_out;
  logic             uop_valid;
  logic             uop_ready;
  logic             uop_last;
  logic             busy;

  modport master (
    input  flush, feed_ack, uop_0, uop_1, uop_2, uop_count, uop_ready,
    output feed_req, uop_out, uop_valid, uop_last, busy
  );

  modport slave (
    output flush, feed_ack, uop_0, uop_1, uop_2, uop_count, uop_ready,
    input  feed_req, uop_out, uop_valid, uop_last, busy
  );
endinterface

// File: rtl/uop_sequencer.sv
// Buffers decoded uop bundles and issues them one uop per cycle, highest index first.
// Optional UOP_SEQ_BYPASS_EN: a count-0 bundle into an empty FIFO issues in the same cycle.
module uop_sequencer #(
  parameter int UOP_W = 20,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               a_rst,
  uop_sequencer_if.master    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {EMPTY, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nx;
  logic [OCC_W-1:0] occ_q;
  logic [UOP_W-1:0] uop_mem [DEPTH][3];
  logic [1:0]       cnt_mem [DEPTH];

  logic [1:0] in_cnt;
  logic       feed_req, push, fire, pop, bypass_take;

  always_comb begin
    feed_req  = occ_q < OCC_W'(DEPTH);
    in_cnt    = (bus.uop_count == 2'd3) ? 2'd2 : bus.uop_count;
    rd_ptr_nx = rd_ptr_q + PTR_W'(1);
    fire      = (state_q == ISSUE) && bus.uop_ready;
    pop       = fire && (step_q == 2'd0);
`ifdef UOP_SEQ_BYPASS_EN
    bypass_take = (occ_q == '0) && !bus.flush && bus.feed_ack &&
                  (bus.uop_count == 2'd0) && bus.uop_ready;
`else
    bypass_take = 1'b0;
`endif
    push = bus.feed_ack && feed_req && !bus.flush && !bypass_take;
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q <= EMPTY;
      step_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // When the head pops, the next head may be the bundle being written this very cycle.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ISSUE;
          step_d  = in_cnt;
        end
      end
      ISSUE: begin
        if (fire) begin
          if (step_q != 2'd0) begin
            step_d = step_q - 2'd1;
          end else if (occ_q > OCC_W'(1)) begin
            step_d = cnt_mem[rd_ptr_nx];
          end else if (push) begin
            step_d = in_cnt;
          end else begin
            state_d = EMPTY;
            step_d  = 2'd0;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        step_d  = 2'd0;
      end
    endcase
    if (bus.flush) begin
      state_d = EMPTY;
      step_d  = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_nx;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Bundle storage needs no reset; the output mux is gated by uop_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      uop_mem[wr_ptr_q][0] <= bus.uop_0;
      uop_mem[wr_ptr_q][1] <= bus.uop_1;
      uop_mem[wr_ptr_q][2] <= bus.uop_2;
      cnt_mem[wr_ptr_q]    <= in_cnt;
    end
  end

  always_comb begin
    bus.feed_req  = feed_req;
    bus.busy      = (occ_q != '0);
    bus.uop_valid = (state_q == ISSUE);
    bus.uop_last  = (state_q == ISSUE) && (step_q == 2'd0);
    bus.uop_out   = (state_q == ISSUE) ? uop_mem[rd_ptr_q][step_q] : '0;
`ifdef UOP_SEQ_BYPASS_EN
    if ((occ_q == '0) && !bus.flush && bus.feed_ack && (bus.uop_count == 2'd0)) begin
      bus.uop_out   = bus.uop_0;
      bus.uop_valid = 1'b1;
      bus.uop_last  = 1'b1;
    end
`endif
  end
endmodule
